// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions. On resolve it issues the next
// 2-bit counter value to the pattern table, flags mispredictions and flushes younger entries.
module branch_resolve_queue #(
    parameter int IDX_W = 6,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [IDX_W-1:0]         pred_idx,
    input  logic [1:0]               pred_ctr,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_idx,
    output logic [1:0]               upd_ctr,
    output logic                     mispredict,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stat_resolved,
    output logic [CNT_W-1:0]         stat_mispred
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [IDX_W-1:0] idx_mem_r [DEPTH];
    logic [1:0]       ctr_mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic             upd_valid_r;
    logic [IDX_W-1:0] upd_idx_r;
    logic [1:0]       upd_ctr_r;
    logic             mispredict_r;
    logic             res_err_r;
    logic [CNT_W-1:0] stat_resolved_r;
    logic [CNT_W-1:0] stat_mispred_r;

    logic             push_s;
    logic             pop_s;
    logic             err_s;
    logic             mis_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [1:0]       head_ctr_s;
    logic [1:0]       new_ctr_s;
    logic [OCC_W-1:0] count_nxt_s;

    assign pred_ready    = (count_r != FULL_OCC);
    assign count         = count_r;
    assign upd_valid     = upd_valid_r;
    assign upd_idx       = upd_idx_r;
    assign upd_ctr       = upd_ctr_r;
    assign mispredict    = mispredict_r;
    assign res_err       = res_err_r;
    assign stat_resolved = stat_resolved_r;
    assign stat_mispred  = stat_mispred_r;

    // Handshake decode, head-entry resolution and next occupancy.
    always_comb begin
        push_s      = pred_valid && pred_ready;
        pop_s       = res_valid && (count_r != {OCC_W{1'b0}});
        err_s       = res_valid && (count_r == {OCC_W{1'b0}});
        head_idx_s  = idx_mem_r[rd_ptr_r];
        head_ctr_s  = ctr_mem_r[rd_ptr_r];
        new_ctr_s   = sat_ctr(head_ctr_s, res_taken);
        mis_s       = pop_s && (head_ctr_s[1] != res_taken);
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + OCC_W'(1);
            2'b01:   count_nxt_s = count_r - OCC_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage; a push coinciding with a flush is discarded.
    always_ff @(posedge clk) begin
        if (push_s && !mis_s) begin
            idx_mem_r[wr_ptr_r] <= pred_idx;
            ctr_mem_r[wr_ptr_r] <= pred_ctr;
        end
    end

    // Pointers, occupancy, registered update outputs and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r        <= {PTR_W{1'b0}};
            wr_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {OCC_W{1'b0}};
            upd_valid_r     <= 1'b0;
            upd_idx_r       <= {IDX_W{1'b0}};
            upd_ctr_r       <= 2'd0;
            mispredict_r    <= 1'b0;
            res_err_r       <= 1'b0;
            stat_resolved_r <= {CNT_W{1'b0}};
            stat_mispred_r  <= {CNT_W{1'b0}};
        end else begin
            upd_valid_r  <= pop_s;
            mispredict_r <= mis_s;
            res_err_r    <= err_s;
            if (pop_s) begin
                upd_idx_r <= head_idx_s;
                upd_ctr_r <= new_ctr_s;
                if (stat_resolved_r != STAT_MAX) begin
                    stat_resolved_r <= stat_resolved_r + CNT_W'(1);
                end
            end
            if (mis_s && (stat_mispred_r != STAT_MAX)) begin
                stat_mispred_r <= stat_mispred_r + CNT_W'(1);
            end
            // A misprediction discards all younger work, including this cycle's push.
            if (mis_s) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {OCC_W{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                count_r <= count_nxt_s;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: a queue-based reference model checked every
// cycle, plus literal expectations taken from hand-worked scenarios.
module tb_branch_resolve_queue;

    localparam int IDX_W = 6;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pred_valid = 1'b0;
    logic [IDX_W-1:0] pred_idx = '0;
    logic [1:0]       pred_ctr = 2'd0;
    logic             pred_ready;
    logic             res_valid = 1'b0;
    logic             res_taken = 1'b0;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic [1:0]       upd_ctr;
    logic             mispredict;
    logic             res_err;
    logic [3:0]       count;
    logic [CNT_W-1:0] stat_resolved;
    logic [CNT_W-1:0] stat_mispred;

    int checks = 0;
    int errors = 0;

    branch_resolve_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_ctr(pred_ctr), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_ctr(upd_ctr),
        .mispredict(mispredict), .res_err(res_err), .count(count),
        .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order list of {idx, ctr}, updated at each clock edge.
    int q_idx[$];
    int q_ctr[$];
    int e_upd_valid = 0, e_upd_idx = 0, e_upd_ctr = 0, e_mis = 0, e_err = 0;
    int e_res = 0, e_misn = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_idx.delete(); q_ctr.delete();
            e_upd_valid = 0; e_upd_idx = 0; e_upd_ctr = 0; e_mis = 0; e_err = 0;
            e_res = 0; e_misn = 0;
        end else begin
            int c, ix, nc;
            bit room, flush, predicted_taken;
            room = (q_idx.size() < DEPTH);
            flush = 0;
            e_upd_valid = 0; e_mis = 0; e_err = 0;
            if (res_valid) begin
                if (q_idx.size() == 0) begin
                    e_err = 1;
                end else begin
                    ix = q_idx.pop_front();
                    c  = q_ctr.pop_front();
                    if (res_taken) nc = (c + 1 > 3) ? 3 : c + 1;
                    else           nc = (c - 1 < 0) ? 0 : c - 1;
                    e_upd_valid = 1; e_upd_idx = ix; e_upd_ctr = nc;
                    if (e_res < 65535) e_res++;
                    predicted_taken = (c >= 2);
                    if (predicted_taken != res_taken) begin
                        e_mis = 1; flush = 1;
                        if (e_misn < 65535) e_misn++;
                    end
                end
            end
            if (flush) begin
                q_idx.delete(); q_ctr.delete();
            end else if (pred_valid && room) begin
                q_idx.push_back(int'(pred_idx));
                q_ctr.push_back(int'(pred_ctr));
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        chk("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
        chk("mispredict", 32'(mispredict), 32'(e_mis));
        chk("res_err", 32'(res_err), 32'(e_err));
        chk("count", 32'(count), 32'(q_idx.size()));
        chk("pred_ready", 32'(pred_ready), 32'(q_idx.size() != DEPTH));
        chk("stat_resolved", 32'(stat_resolved), 32'(e_res));
        chk("stat_mispred", 32'(stat_mispred), 32'(e_misn));
        if (e_upd_valid != 0) begin
            chk("upd_idx", 32'(upd_idx), 32'(e_upd_idx));
            chk("upd_ctr", 32'(upd_ctr), 32'(e_upd_ctr));
        end
    end

    // Apply inputs at a falling edge and return at the next one, after the rising edge.
    task automatic step(input bit pv, input int idx, input int ctr, input bit rv, input bit rt);
        pred_valid = pv;
        pred_idx   = IDX_W'(idx);
        pred_ctr   = 2'(ctr);
        res_valid  = rv;
        res_taken  = rt;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    int fill_ctr[8] = '{2, 3, 0, 1, 3, 2, 1, 0};

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset pred_ready", 32'(pred_ready), 32'd1);
        chk("reset upd_valid", 32'(upd_valid), 32'd0);
        rst = 1'b0;

        // Basic push then taken resolve: 2 -> 3, correct prediction.
        step(1, 5, 2, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("basic upd_valid", 32'(upd_valid), 32'd1);
        chk("basic upd_idx", 32'(upd_idx), 32'd5);
        chk("basic upd_ctr", 32'(upd_ctr), 32'd3);
        chk("basic mispredict", 32'(mispredict), 32'd0);
        chk("basic count", 32'(count), 32'd0);
        chk("basic stat_resolved", 32'(stat_resolved), 32'd1);

        // Saturation at both ends.
        step(1, 11, 3, 0, 0);
        step(1, 12, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("sat high upd_ctr", 32'(upd_ctr), 32'd3);
        step(0, 0, 0, 1, 0);
        chk("sat low upd_ctr", 32'(upd_ctr), 32'd0);
        chk("sat low mispredict", 32'(mispredict), 32'd0);

        // Mispredict flushes younger entries and the same-cycle push.
        step(1, 1, 1, 0, 0);
        step(1, 2, 2, 0, 0);
        step(1, 3, 2, 0, 0);
        step(1, 9, 3, 1, 1);
        chk("flush mispredict", 32'(mispredict), 32'd1);
        chk("flush upd_ctr", 32'(upd_ctr), 32'd2);
        chk("flush count", 32'(count), 32'd0);
        chk("flush pred_ready", 32'(pred_ready), 32'd1);
        chk("flush stat_mispred", 32'(stat_mispred), 32'd1);
        idle();
        chk("mispredict pulse width", 32'(mispredict), 32'd0);

        // Offset the pointers, then fill so the ring wraps.
        for (int i = 0; i < 3; i++) step(1, 20 + i, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 30 + i, fill_ctr[i], 0, 0);
        chk("full count", 32'(count), 32'd8);
        chk("full pred_ready", 32'(pred_ready), 32'd0);
        step(1, 63, 3, 1, 1);
        chk("full refused push count", 32'(count), 32'd7);
        chk("wrap first upd_idx", 32'(upd_idx), 32'd30);
        for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 1, fill_ctr[i][1]);
        chk("wrap last upd_idx", 32'(upd_idx), 32'd37);
        chk("drained count", 32'(count), 32'd0);

        // Resolve on empty queue, with a same-cycle push accepted.
        step(1, 7, 1, 1, 0);
        chk("empty res_err", 32'(res_err), 32'd1);
        chk("empty upd_valid", 32'(upd_valid), 32'd0);
        chk("empty stat_resolved", 32'(stat_resolved), 32'd15);
        chk("empty stat_mispred", 32'(stat_mispred), 32'd1);
        chk("empty push count", 32'(count), 32'd1);
        idle();
        chk("res_err pulse width", 32'(res_err), 32'd0);

        // Async reset with entries queued and an update pulse live.
        step(1, 40, 2, 0, 0);
        step(1, 41, 2, 0, 0);
        step(1, 42, 2, 0, 0);
        step(1, 43, 2, 1, 0);
        chk("pre-reset count", 32'(count), 32'd4);
        chk("pre-reset upd_valid", 32'(upd_valid), 32'd1);
        pred_valid = 1'b0; res_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async upd_valid", 32'(upd_valid), 32'd0);
        chk("async count", 32'(count), 32'd0);
        chk("async pred_ready", 32'(pred_ready), 32'd1);
        chk("async stat_resolved", 32'(stat_resolved), 32'd0);
        chk("async stat_mispred", 32'(stat_mispred), 32'd0);
        chk("async upd_idx", 32'(upd_idx), 32'd0);
        chk("async upd_ctr", 32'(upd_ctr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 1, 1);
        chk("post-reset res_err", 32'(res_err), 32'd1);
        chk("post-reset upd_valid", 32'(upd_valid), 32'd0);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
